// File: rtl/water_level_encoder.sv
// ---------------------------------------------------------------------------
// water_level_encoder
//
// Turns three asynchronous tank probes into a debounced 2-bit level code
// for a 7-segment level decoder. It also flags probe faults: an accepted
// pattern that is not a thermometer code (for example a high probe wet
// while the mid probe is dry).
//
// Ports
//   clk      : single clock; all state changes on the rising edge
//   reset_n  : asynchronous, active-low reset
//   S_Low    : low-level probe, active-high, asynchronous to clk
//   S_Mid    : mid-level probe, active-high, asynchronous to clk
//   S_High   : high-level probe, active-high, asynchronous to clk
//   Bit1     : MSB of the accepted level code (registered)
//   Bit0     : LSB of the accepted level code (registered)
//   Error    : 1 while the last accepted pattern was not a thermometer code
//   Update   : one-cycle strobe after a commit that changed {Bit1,Bit0}
//
// Parameter
//   DEBOUNCE_CYCLES : number of consecutive synchronized clocks a new probe
//                     pattern must hold before it is accepted (2..255)
// ---------------------------------------------------------------------------
module water_level_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic S_Low,
    input  logic S_Mid,
    input  logic S_High,
    output logic Bit1,
    output logic Bit0,
    output logic Error,
    output logic Update
);

    // The counter value at which a matching sample completes the debounce.
    // The counter is already 1 on the first sample of a new pattern, so the
    // DEBOUNCE_CYCLES-th consecutive sample is the one that sees CNT_LAST.
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE = 2'd0,
        SETTLE = 2'd1,
        FAULT  = 2'd2
    } state_t;

    // Probe pattern ordering throughout: {S_High, S_Mid, S_Low}.
    logic [2:0] sync_meta;
    logic [2:0] sync_p;

    state_t     state;
    state_t     state_n;
    logic [2:0] acc;
    logic [2:0] acc_n;
    logic [2:0] cand;
    logic [2:0] cand_n;
    logic [7:0] cnt;
    logic [7:0] cnt_n;
    logic [1:0] code;
    logic [1:0] code_n;
    logic       error_n;
    logic       update_n;

    // Thermometer patterns are the only physically consistent probe states.
    function automatic logic pattern_valid(input logic [2:0] p);
        case (p)
            3'b000, 3'b001, 3'b011, 3'b111: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] pattern_code(input logic [2:0] p);
        case (p)
            3'b001:  return 2'b01;
            3'b011:  return 2'b10;
            3'b111:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Two-flop synchronizer on every probe
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '0;
            sync_p    <= '0;
        end else begin
            sync_meta <= {S_High, S_Mid, S_Low};
            sync_p    <= sync_meta;
        end
    end

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= STABLE;
            acc    <= '0;
            cand   <= '0;
            cnt    <= '0;
            code   <= '0;
            Error  <= 1'b0;
            Update <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            cand   <= cand_n;
            cnt    <= cnt_n;
            code   <= code_n;
            Error  <= error_n;
            Update <= update_n;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_n  = state;
        acc_n    = acc;
        cand_n   = cand;
        cnt_n    = cnt;
        code_n   = code;
        error_n  = Error;
        update_n = 1'b0;

        case (state)
            // STABLE and FAULT behave alike; they differ only in the Error
            // flag, which is simply held here.
            STABLE, FAULT: begin
                if (sync_p != acc) begin
                    cand_n  = sync_p;
                    cnt_n   = 8'd1;
                    state_n = SETTLE;
                end else begin
                    cnt_n = '0;
                end
            end

            SETTLE: begin
                if (sync_p != cand) begin
                    if (sync_p == acc) begin
                        // Glitch ended: go back without touching the outputs.
                        cnt_n   = '0;
                        state_n = Error ? FAULT : STABLE;
                    end else begin
                        // A different new pattern: restart the debounce on it.
                        cand_n = sync_p;
                        cnt_n  = 8'd1;
                    end
                end else if (cnt == CNT_LAST) begin
                    acc_n = cand;
                    cnt_n = '0;
                    if (pattern_valid(cand)) begin
                        code_n   = pattern_code(cand);
                        error_n  = 1'b0;
                        update_n = (pattern_code(cand) != code);
                        state_n  = STABLE;
                    end else begin
                        // Probe fault: keep the last good level on display.
                        error_n = 1'b1;
                        state_n = FAULT;
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end

            default: begin
                state_n = STABLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign Bit1 = code[1];
    assign Bit0 = code[0];

endmodule

// File: tb/tb_water_level_encoder.sv
// ---------------------------------------------------------------------------
// tb_water_level_encoder
//
// Directed scenarios followed by randomized probe bursts, each edge checked
// against a reference model. The model only knows the input delay through
// the synchronizer and the rule "a pattern seen for D consecutive samples
// that differs from the accepted one is accepted".
// ---------------------------------------------------------------------------
module tb_water_level_encoder;

    localparam int unsigned D = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic s_low   = 1'b0;
    logic s_mid   = 1'b0;
    logic s_high  = 1'b0;
    logic bit1;
    logic bit0;
    logic error;
    logic update;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [2:0] m_s1;
    logic [2:0] m_s2;
    logic [2:0] m_prev;
    logic [2:0] m_acc;
    int         m_run;
    logic [1:0] m_code;
    logic       m_err;
    logic       m_upd;

    water_level_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .S_Low   (s_low),
        .S_Mid   (s_mid),
        .S_High  (s_high),
        .Bit1    (bit1),
        .Bit0    (bit0),
        .Error   (error),
        .Update  (update)
    );

    always #5 clk = ~clk;

    function automatic logic thermo(input logic [2:0] p);
        int n;
        n = $countones(p);
        return (p == 3'((32'd1 << n) - 1));
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed {b1,b0,err,upd}=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] outs();
        return {bit1, bit0, error, update};
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_prev = '0; m_acc = '0;
        m_run = 0; m_code = '0; m_err = 1'b0; m_upd = 1'b0;
    endtask

    // One rising edge of the model; in_now is what the first sync flop captures.
    task automatic model_edge(input logic [2:0] in_now);
        logic [2:0] p;
        logic [1:0] c;
        p = m_s2;
        m_upd = 1'b0;
        if (p == m_prev) begin
            if (m_run < 255) m_run++;
        end else begin
            m_run = 1;
        end
        m_prev = p;
        if (m_run == int'(D) && p != m_acc) begin
            m_acc = p;
            if (thermo(p)) begin
                c = 2'($countones(p));
                m_upd  = (c != m_code);
                m_code = c;
                m_err  = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
        m_s2 = m_s1;
        m_s1 = in_now;
    endtask

    // Called 1 time unit after a rising edge; drives, clocks, checks.
    task automatic step(input logic [2:0] in, input string tag);
        {s_high, s_mid, s_low} = in;
        @(posedge clk);
        model_edge(in);
        #1 check(tag, outs(), {m_code, m_err, m_upd});
    endtask

    task automatic hold(input logic [2:0] in, input int n, input string tag);
        for (int i = 0; i < n; i++) step(in, tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset(input logic [2:0] in_after);
        #3 reset_n = 1'b0;
        model_reset();
        #1 check("reset_async", outs(), 4'b0000);
        {s_high, s_mid, s_low} = in_after;
        #2 reset_n = 1'b1;
    endtask

    task automatic edges_to_update(input logic [2:0] in, input string tag);
        int  n;
        bit  found;
        n = 0;
        found = 1'b0;
        while (!found && n < 20) begin
            step(in, tag);
            n++;
            if (update === 1'b1) found = 1'b1;
        end
        check_int({tag, "_latency"}, found ? n : -1, int'(D) + 2);
    endtask

    initial begin
        logic [2:0] pat;
        int         len;

        model_reset();
        {s_high, s_mid, s_low} = 3'b000;
        #1 check("reset_initial", outs(), 4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            {s_high, s_mid, s_low} = 3'($urandom);
            #1 check("reset_held", outs(), 4'b0000);
        end
        {s_high, s_mid, s_low} = 3'b000;
        #2 reset_n = 1'b1;

        // Idle with dry probes
        hold(3'b000, 12, "idle_000");
        check("idle_final", outs(), 4'b0000);

        // Clean step to mid level
        edges_to_update(3'b011, "step_011");
        check("step_011_commit", outs(), 4'b1001);
        step(3'b011, "step_011_after");
        check("update_one_cycle", outs(), 4'b1000);
        hold(3'b011, 4, "hold_011");

        // High-probe glitch shorter than the debounce window
        hold(3'b111, 3, "glitch_111");
        hold(3'b011, 8, "after_glitch");
        check("glitch_ignored", outs(), 4'b1000);

        // Fault pattern then recovery
        hold(3'b001, 10, "to_001");
        check("level_01", outs(), 4'b0100);
        hold(3'b101, 5, "fault_pre");
        check("fault_not_yet", outs(), 4'b0100);
        step(3'b101, "fault_commit");
        check("fault_flag", outs(), 4'b0110);
        hold(3'b101, 4, "fault_hold");
        hold(3'b111, 5, "recover_pre");
        check("recover_not_yet", outs(), 4'b0110);
        step(3'b111, "recover_commit");
        check("recover_11", outs(), 4'b1101);
        hold(3'b111, 4, "hold_111");

        // Staggered probe changes restart the debounce
        hold(3'b000, 10, "to_000");
        hold(3'b001, 2, "stagger_001");
        hold(3'b011, 5, "stagger_011_pre");
        check("stagger_no_01", outs(), 4'b0000);
        step(3'b011, "stagger_commit");
        check("stagger_10", outs(), 4'b1001);
        hold(3'b011, 3, "stagger_hold");

        // Reset in the middle of a settle discards the candidate
        hold(3'b000, 10, "to_000b");
        hold(3'b111, 5, "settle_111");
        pulse_reset(3'b000);
        hold(3'b000, 12, "post_reset_000");
        check("post_reset_quiet", outs(), 4'b0000);

        // Probes already wet when reset releases are still debounced
        hold(3'b011, 3, "pre_reset_011");
        pulse_reset(3'b011);
        edges_to_update(3'b011, "wet_at_release");
        hold(3'b011, 3, "wet_hold");

        // Randomized bursts
        for (int b = 0; b < 70; b++) begin
            pat = 3'($urandom_range(7, 0));
            len = $urandom_range(7, 1);
            hold(pat, len, "random");
            if ($urandom_range(24, 0) == 0) pulse_reset(3'($urandom_range(7, 0)));
        end
        hold(3'b000, 10, "final_000");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed time=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
